// File: rtl/finder_row_scanner_if.sv
// Pixel read bus toward the filtered-frame BRAM and the candidate stream toward the consumer.
// The scanner drives through the master view; the BRAM/consumer side uses the slave view.
interface finder_row_scanner_if;
    logic [18:0] pixel_address;
    logic        pixel_data;
    logic [8:0]  cand_x;
    logic [8:0]  cand_y;
    logic [11:0] cand_width;
    logic        cand_valid;
    logic        cand_ready;

    modport master (
        output pixel_address, cand_x, cand_y, cand_width, cand_valid,
        input  pixel_data, cand_ready
    );

    modport slave (
        input  pixel_address, cand_x, cand_y, cand_width, cand_valid,
        output pixel_data, cand_ready
    );
endinterface

// File: rtl/finder_row_scanner.sv
// Raster-scans the filtered binary frame, run-length encodes each row and reports
// dark:light:dark:light:dark groups near the 1:1:3:1:1 finder ratio through a small FIFO.
module finder_row_scanner #(
    parameter int WIDTH        = 480,
    parameter int HEIGHT       = 480,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int MIN_TOTAL    = 7
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 start_scan,
    finder_row_scanner_if.master bus,
    output logic                 scan_busy,
    output logic                 scan_finished,
    output logic [7:0]           cand_count
);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SUM_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;
    localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [11:0] w;
    } cand_t;

    state_t                          state;
    logic [8:0]                      scan_x, scan_y;
    logic [18:0]                     addr;
    logic [READ_LATENCY-1:0]         tag_vld;
    logic [READ_LATENCY-1:0][8:0]    tag_x, tag_y;
    logic [SUM_W-1:0]                in_flight;
    logic                            issue, last_addr;

    logic [8:0]                      run_len;
    logic                            run_colour;
    logic [4:0][8:0]                 hist;
    logic [2:0]                      nruns;

    logic                            in_valid, px, first_px, last_px, change, use_a, use_b;
    logic                            ratio_ok, fire;
    logic [8:0]                      in_x, in_y, new_len;
    logic [4:0][8:0]                 hist_a, hist_b, chk;
    logic [2:0]                      n_a, n_b, chk_n;
    logic [9:0]                      chk_e;
    logic [11:0]                     total;
    logic [13:0]                     t14;
    cand_t                           cand_calc, pend, head;
    logic                            pend_valid;

    cand_t                           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                wr_ptr, rd_ptr;
    logic [OCC_W-1:0]                occ;
    logic                            pop;

    function automatic logic [2:0] sat_inc(input logic [2:0] n);
        return (n >= 3'd5) ? 3'd5 : n + 3'd1;
    endfunction

    function automatic logic in_band(input logic [8:0] r, input logic [13:0] lo,
                                     input logic [13:0] hi);
        logic [13:0] p;
        p = 14'(r) * 14'd14;
        return (p >= lo) && (p <= hi);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Every slot that could still turn into a FIFO entry is reserved before a read is issued.
    always_comb begin
        // NOTE: combinational outputs get a value on every path before any update, so no latch is inferred.
        in_flight = '0;
        for (int i = 0; i < READ_LATENCY; i++)
            in_flight = in_flight + SUM_W'(tag_vld[i]);
        issue = (state == SCAN) &&
                (SUM_W'(occ) + in_flight + SUM_W'(pend_valid) < SUM_W'(FIFO_DEPTH));
        last_addr = (scan_x == X_LAST) && (scan_y == Y_LAST);
    end

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses <= so every register here sees pre-edge values of the others.
        if (!rst_n_in) begin
            state         <= IDLE;
            scan_x        <= '0;
            scan_y        <= '0;
            addr          <= '0;
            scan_busy     <= 1'b0;
            scan_finished <= 1'b0;
            cand_count    <= '0;
        end else begin
            scan_finished <= 1'b0;
            if (pend_valid && cand_count != 8'hFF)
                cand_count <= cand_count + 8'd1;
            case (state)
                IDLE: if (start_scan) begin
                    state      <= SCAN;
                    scan_x     <= '0;
                    scan_y     <= '0;
                    addr       <= '0;
                    scan_busy  <= 1'b1;
                    cand_count <= '0;
                end
                SCAN: if (issue) begin
                    addr <= addr + 19'd1;
                    if (scan_x == X_LAST) begin
                        scan_x <= '0;
                        scan_y <= scan_y + 9'd1;
                    end else begin
                        scan_x <= scan_x + 9'd1;
                    end
                    if (last_addr)
                        state <= DRAIN;
                end
                DRAIN: if (tag_vld == '0 && !pend_valid) begin
                    state         <= DONE;
                    scan_busy     <= 1'b0;
                    scan_finished <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        tag_x[0] <= scan_x;
        tag_y[0] <= scan_y;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_x[i] <= tag_x[i-1];
            tag_y[i] <= tag_y[i-1];
        end
        if (!rst_n_in) begin
            tag_vld <= '0;
        end else begin
            tag_vld[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++)
                tag_vld[i] <= tag_vld[i-1];
        end
    end

    // A pixel can close the previous run (colour change) and, at x==WIDTH-1, its own run too;
    // only one of the two closing runs can be dark, so a single checker suffices.
    always_comb begin
        in_valid = tag_vld[READ_LATENCY-1];
        in_x     = tag_x[READ_LATENCY-1];
        in_y     = tag_y[READ_LATENCY-1];
        px       = bus.pixel_data;
        first_px = (in_x == '0);
        last_px  = (in_x == X_LAST);
        change   = !first_px && (px != run_colour);
        hist_a   = change ? {run_len, hist[4:1]} : hist;
        n_a      = change ? sat_inc(nruns) : nruns;
        new_len  = (first_px || change) ? 9'd1 : run_len + 9'd1;
        hist_b   = {new_len, hist_a[4:1]};
        n_b      = sat_inc(n_a);
        use_a    = change && run_colour;
        use_b    = last_px && px;
        chk      = use_b ? hist_b : hist_a;
        chk_n    = use_b ? n_b : n_a;
        chk_e    = use_b ? 10'(WIDTH) : {1'b0, in_x};
        total    = 12'(chk[0]) + 12'(chk[1]) + 12'(chk[2]) + 12'(chk[3]) + 12'(chk[4]);
        t14      = 14'(total);
        ratio_ok = in_band(chk[0], t14, 14'd3 * t14) && in_band(chk[1], t14, 14'd3 * t14) &&
                   in_band(chk[3], t14, 14'd3 * t14) && in_band(chk[4], t14, 14'd3 * t14) &&
                   in_band(chk[2], 14'd5 * t14, 14'd7 * t14);
        fire     = in_valid && (use_a || use_b) && (chk_n == 3'd5) && ratio_ok &&
                   (total >= 12'(MIN_TOTAL));
        cand_calc.x = 9'(chk_e - 10'(chk[4]) - 10'(chk[3]) - 10'(chk[2]) + 10'(chk[2] >> 1));
        cand_calc.y = in_y;
        cand_calc.w = total;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            run_len    <= '0;
            run_colour <= 1'b0;
            hist       <= '0;
            nruns      <= '0;
            pend_valid <= 1'b0;
        end else begin
            pend_valid <= fire;
            if (in_valid) begin
                run_colour <= px;
                run_len    <= new_len;
                if (first_px) begin
                    hist  <= '0;
                    nruns <= '0;
                end else begin
                    hist  <= hist_a;
                    nruns <= n_a;
                end
            end
        end
    end

    // NOTE: payload storage is not reset; occupancy alone defines validity and outputs are gated while empty.
    always_ff @(posedge clk_in) begin
        pend <= cand_calc;
        if (pend_valid)
            fifo_mem[wr_ptr] <= pend;
    end

    assign pop = bus.cand_valid && bus.cand_ready;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (pend_valid) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)        rd_ptr <= ptr_inc(rd_ptr);
            case ({pend_valid, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head              = fifo_mem[rd_ptr];
    assign bus.cand_valid    = (occ != '0);
    assign bus.cand_x        = bus.cand_valid ? head.x : '0;
    assign bus.cand_y        = bus.cand_valid ? head.y : '0;
    assign bus.cand_width    = bus.cand_valid ? head.w : '0;
    assign bus.pixel_address = addr;
endmodule
